// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the two-requester REGBank port arbiter.
// Holds the arbitration state encoding, default widths and request-slot helpers.
package regbank_arb_pkg;

   localparam int DW_DEF       = 16;
   localparam int AW_DEF       = 4;
   localparam int LOCK_MAX_DEF = 4;
   localparam int N_REQ        = 2;

   // Lowest bit of each requester's slot inside the packed per-requester buses
   localparam int REQ0_SLOT = 0;
   localparam int REQ1_SLOT = 1;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/regbank_rr_pick.sv
// Combinational two-way pick: a non-zero force mask restricts eligibility to the
// masked requester; when both remain eligible the priority bit breaks the tie.
module regbank_rr_pick
   import regbank_arb_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_prio,
   input  logic [1:0] i_force_mask,
   output logic [1:0] o_grant
);

   logic [1:0] w_elig;

   always_comb begin
      w_elig  = (i_force_mask == 2'b00) ? i_valid : (i_valid & i_force_mask);
      o_grant = 2'b00;
      case (w_elig)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = onehot2(i_prio);
         default: o_grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/regbank_port_arbiter.sv
// Shares the REGBank write port and two read ports between two requesters with
// round-robin arbitration, a bounded ownership lock and a registered read return.
module regbank_port_arbiter
   import regbank_arb_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0]      req_we,
   input  logic [1:0]      req_lock,
   input  logic [2*AW-1:0] req_dest,
   input  logic [2*DW-1:0] req_data,
   input  logic [2*AW-1:0] req_src1,
   input  logic [2*AW-1:0] req_src2,
   output logic [1:0]      rsp_valid,
   output logic [DW-1:0]   rsp_data1,
   output logic [DW-1:0]   rsp_data2,
   output logic            rw,
   output logic [AW-1:0]   dest,
   output logic [DW-1:0]   dataIn,
   output logic [AW-1:0]   nReg1,
   output logic [AW-1:0]   nReg2,
   input  logic [DW-1:0]   reg1out,
   input  logic [DW-1:0]   reg2out
);

   localparam int             CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0]  LOCK_MAX_C = CW'(LOCK_MAX);
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

   arb_state_e      r_state;
   logic            r_rr_ptr;
   logic [CW-1:0]   r_lock_cnt;
   logic [1:0]      r_rsp_valid;
   logic [DW-1:0]   r_rsp_data1;
   logic [DW-1:0]   r_rsp_data2;

   logic            w_locked;
   logic            w_owner;
   logic            w_forced;
   logic [1:0]      w_mask;
   logic [1:0]      w_pick;
   logic [1:0]      w_grant;
   logic            w_fire;
   logic            w_gidx;
   logic            w_gwe;
   logic            w_rd_fire;

   always_comb begin
      w_locked = (r_state != ARB);
      w_owner  = (r_state == LOCK1);
      // Once the lock has been held LOCK_MAX cycles, a waiting requester takes over
      w_forced = w_locked && (r_lock_cnt == LOCK_MAX_C) && req_valid[~w_owner];
      if (!w_locked)
         w_mask = 2'b00;
      else if (w_forced)
         w_mask = onehot2(~w_owner);
      else
         w_mask = onehot2(w_owner);
   end

   regbank_rr_pick u_pick (
      .i_valid      (req_valid),
      .i_prio       (r_rr_ptr),
      .i_force_mask (w_mask),
      .o_grant      (w_pick)
   );

   assign w_grant   = rst ? 2'b00 : w_pick;
   assign w_fire    = |w_grant;
   assign w_gidx    = w_grant[REQ1_SLOT];
   assign w_gwe     = req_we[w_gidx];
   assign w_rd_fire = w_fire && !w_gwe;
   assign req_ready = w_grant;

   always_comb begin
      rw     = 1'b0;
      dest   = '0;
      dataIn = '0;
      nReg1  = '0;
      nReg2  = '0;
      if (w_fire) begin
         rw     = w_gwe;
         dest   = w_gidx ? req_dest[AW +: AW] : req_dest[0 +: AW];
         dataIn = w_gidx ? req_data[DW +: DW] : req_data[0 +: DW];
         nReg1  = w_gidx ? req_src1[AW +: AW] : req_src1[0 +: AW];
         nReg2  = w_gidx ? req_src2[AW +: AW] : req_src2[0 +: AW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ARB;
         r_rr_ptr    <= 1'b0;
         r_lock_cnt  <= '0;
         r_rsp_valid <= 2'b00;
         r_rsp_data1 <= '0;
         r_rsp_data2 <= '0;
      end else begin
         r_rsp_valid <= w_rd_fire ? w_grant : 2'b00;
         if (w_rd_fire) begin
            r_rsp_data1 <= reg1out;
            r_rsp_data2 <= reg2out;
         end
         case (r_state)
            ARB: begin
               if (w_fire) begin
                  r_rr_ptr <= ~w_gidx;
                  if (req_lock[w_gidx]) begin
                     r_state    <= w_gidx ? LOCK1 : LOCK0;
                     r_lock_cnt <= CNT_ONE;
                  end
               end
            end
            LOCK0, LOCK1: begin
               if (w_forced) begin
                  r_rr_ptr <= w_owner;
                  if (req_lock[~w_owner]) begin
                     r_state    <= w_owner ? LOCK0 : LOCK1;
                     r_lock_cnt <= CNT_ONE;
                  end else begin
                     r_state    <= ARB;
                     r_lock_cnt <= '0;
                  end
               end else begin
                  // Timer keeps running even while the owner is stalled
                  r_lock_cnt <= (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt : r_lock_cnt + CNT_ONE;
                  if (w_fire && !req_lock[w_owner]) begin
                     r_state    <= ARB;
                     r_rr_ptr   <= ~w_owner;
                     r_lock_cnt <= '0;
                  end
               end
            end
            default: begin
               r_state    <= ARB;
               r_lock_cnt <= '0;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data1 = r_rsp_data1;
   assign rsp_data2 = r_rsp_data2;

endmodule

// File: tb/tb_regbank_port_arbiter.sv
// Bench for regbank_port_arbiter: behavioural register bank plus an ownership
// model of the arbitration rules, directed scenarios and a randomized run.
module tb_regbank_port_arbiter;

   localparam int DW       = 16;
   localparam int AW       = 4;
   localparam int LOCK_MAX = 4;

   logic            clk;
   logic            rst;
   logic [1:0]      v, we, lk;
   logic [2*AW-1:0] dst, s1, s2;
   logic [2*DW-1:0] wd;
   logic [1:0]      req_ready, rsp_valid;
   logic [DW-1:0]   rsp_data1, rsp_data2, dataIn, reg1out, reg2out;
   logic            rw;
   logic [AW-1:0]   dest, nReg1, nReg2;

   regbank_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst), .req_valid(v), .req_ready(req_ready), .req_we(we),
      .req_lock(lk), .req_dest(dst), .req_data(wd), .req_src1(s1), .req_src2(s2),
      .rsp_valid(rsp_valid), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .rw(rw), .dest(dest), .dataIn(dataIn), .nReg1(nReg1), .nReg2(nReg2),
      .reg1out(reg1out), .reg2out(reg2out)
   );

   // Clock and stand-in register bank
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] init_vals [16];
   logic [DW-1:0] bank [16];
   logic          init_bank;
   always @(posedge clk) begin
      if (init_bank) begin
         for (int i = 0; i < 16; i++) bank[i] <= init_vals[i];
      end else if (rw) begin
         bank[dest] <= dataIn;
      end
   end
   assign reg1out = bank[nReg1];
   assign reg2out = bank[nReg2];

   // Reference model: lock owner (-1 = none), cycles held, round-robin favourite
   int            n_tests, n_fail;
   int            m_owner, m_held, m_rr;
   logic [DW-1:0] m_regs [16];
   logic [1:0]    e_grant, e_rsp;
   logic [DW-1:0] e_d1, e_d2, e_din;
   logic          e_rw;
   logic [AW-1:0] e_dest, e_n1, e_n2;
   logic [1:0]    o_ready, o_rsp;
   logic          o_rw;
   logic [AW-1:0] o_dest, o_n1, o_n2;
   logic [DW-1:0] o_din, o_d1, o_d2;

   function automatic logic [1:0] model_pick();
      int other;
      if (m_owner < 0) begin
         if (v == 2'b11) return (m_rr == 1) ? 2'b10 : 2'b01;
         return v;
      end
      other = 1 - m_owner;
      if (m_held >= LOCK_MAX && v[other]) return (other == 1) ? 2'b10 : 2'b01;
      if (v[m_owner]) return (m_owner == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_rr = 0;
      e_rsp = 2'b00; e_d1 = '0; e_d2 = '0;
   endtask

   task automatic model_commit(input logic [1:0] g);
      int gi;
      gi = g[1] ? 1 : (g[0] ? 0 : -1);
      e_rsp = 2'b00;
      if (gi >= 0 && !we[gi]) begin
         e_rsp = g;
         e_d1  = m_regs[s1[gi*AW +: AW]];
         e_d2  = m_regs[s2[gi*AW +: AW]];
      end
      if (gi >= 0 && we[gi]) m_regs[dst[gi*AW +: AW]] = wd[gi*DW +: DW];
      if (m_owner < 0) begin
         if (gi >= 0) begin
            m_rr = 1 - gi;
            if (lk[gi]) begin m_owner = gi; m_held = 1; end
         end
      end else if (gi >= 0 && gi != m_owner) begin
         m_rr = 1 - gi;
         if (lk[gi]) begin m_owner = gi; m_held = 1; end
         else m_owner = -1;
      end else begin
         if (m_held < LOCK_MAX) m_held++;
         if (gi == m_owner && !lk[gi]) begin m_owner = -1; m_rr = 1 - gi; end
      end
   endtask

   // One clock: sample combinational drive mid-cycle, registered response after the edge
   task automatic tick();
      int gi;
      e_grant = model_pick();
      gi = e_grant[1] ? 1 : 0;
      if (|e_grant) begin
         e_rw = we[gi]; e_dest = dst[gi*AW +: AW]; e_din = wd[gi*DW +: DW];
         e_n1 = s1[gi*AW +: AW]; e_n2 = s2[gi*AW +: AW];
      end else begin
         e_rw = 1'b0; e_dest = '0; e_din = '0; e_n1 = '0; e_n2 = '0;
      end
      @(negedge clk);
      o_ready = req_ready; o_rw = rw; o_dest = dest; o_din = dataIn; o_n1 = nReg1; o_n2 = nReg2;
      @(posedge clk);
      model_commit(e_grant);
      #1;
      o_rsp = rsp_valid; o_d1 = rsp_data1; o_d2 = rsp_data2;
   endtask

   // Driver
   task automatic set_req(input int i, input logic vi, input logic wi, input logic li,
                          input logic [AW-1:0] d, input logic [DW-1:0] data,
                          input logic [AW-1:0] a, input logic [AW-1:0] b);
      v[i] = vi; we[i] = wi; lk[i] = li;
      dst[i*AW +: AW] = d; wd[i*DW +: DW] = data; s1[i*AW +: AW] = a; s2[i*AW +: AW] = b;
   endtask

   task automatic test_reset();
      set_req(0, 1'b1, 1'b1, 1'b1, 4'd7, 16'hbeef, 4'd9, 4'd10);
      set_req(1, 1'b1, 1'b1, 1'b0, 4'd6, 16'hcafe, 4'd11, 4'd12);
      repeat (2) @(posedge clk);
      #1;
      init_bank = 1'b0;
      n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
      n_tests++; if (rw !== 1'b0) begin n_fail++; $display("FAIL rst_rw: got %b exp 0", rw); end
      n_tests++; if ({dest, dataIn, nReg1, nReg2} !== '0) begin n_fail++; $display("FAIL rst_drive: got %h exp 0", {dest, dataIn, nReg1, nReg2}); end
      n_tests++; if ({rsp_valid, rsp_data1, rsp_data2} !== '0) begin n_fail++; $display("FAIL rst_rsp: got %h exp 0", {rsp_valid, rsp_data1, rsp_data2}); end
      rst = 1'b0;
      model_reset();
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd10);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd11, 4'd12);
      tick();
      n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b exp 01", o_ready); end
      // Build a lock held by requester 1 with a read just fired
      set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      set_req(1, 1'b1, 1'b1, 1'b1, 4'd2, 16'h1234, 4'd0, 4'd0);
      tick();
      n_tests++; if (o_ready !== 2'b10) begin n_fail++; $display("FAIL rst_lock_grant: got %b exp 10", o_ready); end
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd4, 4'd5);
      set_req(1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 4'd2, 4'd3);
      tick();
      n_tests++; if (o_rsp !== 2'b10 || o_d1 !== 16'h1234) begin n_fail++; $display("FAIL rst_pre_read: got %b/%h exp 10/1234", o_rsp, o_d1); end
      rst = 1'b1;
      #1;
      n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_drop_rsp: got %b exp 00", rsp_valid); end
      n_tests++; if (req_ready !== 2'b00 || rw !== 1'b0 || {nReg1, nReg2} !== '0) begin n_fail++; $display("FAIL rst_mid_drive: got %b/%b/%h exp 00/0/0", req_ready, rw, {nReg1, nReg2}); end
      @(posedge clk);
      #1;
      n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_hold_rsp: got %b exp 00", rsp_valid); end
      rst = 1'b0;
      model_reset();
      set_req(1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 4'd2, 4'd3);
      tick();
      n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL rst_lock_cleared: got %b exp 01", o_ready); end
   endtask

   task automatic test_write_read();
      set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd1, 16'd5, 4'd0, 4'd0);
      tick();
      n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b exp 01", o_ready); end
      n_tests++; if ({o_rw, o_dest, o_din} !== {1'b1, 4'd1, 16'd5}) begin n_fail++; $display("FAIL wr_drive: got %b/%0d/%0d exp 1/1/5", o_rw, o_dest, o_din); end
      n_tests++; if (o_rsp !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp: got %b exp 00", o_rsp); end
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd3);
      tick();
      n_tests++; if ({o_rw, o_n1, o_n2} !== {1'b0, 4'd1, 4'd3}) begin n_fail++; $display("FAIL rd_drive: got %b/%0d/%0d exp 0/1/3", o_rw, o_n1, o_n2); end
      n_tests++; if (o_rsp !== 2'b01 || o_d1 !== 16'd5) begin n_fail++; $display("FAIL rd_rsp: got %b/%0d exp 01/5", o_rsp, o_d1); end
      n_tests++; if (o_d2 !== init_vals[3]) begin n_fail++; $display("FAIL rd_rsp2: got %h exp %h", o_d2, init_vals[3]); end
      set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      tick();
      n_tests++; if (o_rsp !== 2'b00 || o_d1 !== 16'd5) begin n_fail++; $display("FAIL rd_hold: got %b/%0d exp 00/5", o_rsp, o_d1); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      set_req(1, 1'b1, 1'b1, 1'b0, 4'd8, 16'h0808, 4'd0, 4'd0);
      tick();
      for (int k = 0; k < 6; k++) begin
         set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         set_req(1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         n_tests++; if (o_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", k, o_ready, exp_g); end
         n_tests++; if (o_rsp !== exp_g || {o_d1, o_d2} !== {e_d1, e_d2}) begin n_fail++; $display("FAIL rr_rsp%0d: got %b/%h exp %b/%h", k, o_rsp, {o_d1, o_d2}, exp_g, {e_d1, e_d2}); end
      end
   endtask

   task automatic test_lock_sequence();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
      set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h4444, 4'd0, 4'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1'b1, 1'b1, 1'b0, 4'd5, 16'h5555, 4'd0, 4'd0);
         set_req(1, k < 3, 1'b1, k < 2, 4'(10 + k), 16'(16'h1000 + k), 4'd0, 4'd0);
         tick();
         n_tests++; if (o_ready !== exp_g[k]) begin n_fail++; $display("FAIL lock_seq%0d: got %b exp %b", k, o_ready, exp_g[k]); end
      end
   endtask

   task automatic test_lock_timeout();
      logic [1:0] exp_g;
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2);
      set_req(1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 4'd3, 4'd4);
      for (int k = 0; k < 5; k++) begin
         exp_g = (k < 4) ? 2'b10 : 2'b01;
         tick();
         n_tests++; if (o_ready !== exp_g) begin n_fail++; $display("FAIL lock_tmo%0d: got %b exp %b", k, o_ready, exp_g); end
      end
   endtask

   task automatic test_stalled_owner();
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd12, 16'h0c0c, 4'd0, 4'd0);
      set_req(1, 1'b1, 1'b1, 1'b1, 4'd13, 16'h0d0d, 4'd0, 4'd0);
      tick();
      n_tests++; if (o_ready !== 2'b10 || o_rw !== 1'b1) begin n_fail++; $display("FAIL stall_first: got %b/%b exp 10/1", o_ready, o_rw); end
      set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++; if (o_ready !== ((k == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL stall_grant%0d: got %b exp %b", k, o_ready, (k == 3) ? 2'b01 : 2'b00); end
         n_tests++; if (o_rw !== (k == 3)) begin n_fail++; $display("FAIL stall_rw%0d: got %b exp %b", k, o_rw, k == 3); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++)
            set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                    4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick();
         n_tests++; if (o_ready !== e_grant) begin n_fail++; $display("FAIL rnd_grant%0d: got %b exp %b", k, o_ready, e_grant); end
         n_tests++; if ({o_rw, o_dest, o_din, o_n1, o_n2} !== {e_rw, e_dest, e_din, e_n1, e_n2}) begin n_fail++; $display("FAIL rnd_drive%0d: got %h exp %h", k, {o_rw, o_dest, o_din, o_n1, o_n2}, {e_rw, e_dest, e_din, e_n1, e_n2}); end
         n_tests++; if (o_rsp !== e_rsp) begin n_fail++; $display("FAIL rnd_rspv%0d: got %b exp %b", k, o_rsp, e_rsp); end
         n_tests++; if ({o_d1, o_d2} !== {e_d1, e_d2}) begin n_fail++; $display("FAIL rnd_data%0d: got %h exp %h", k, {o_d1, o_d2}, {e_d1, e_d2}); end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; init_bank = 1'b1;
      v = '0; we = '0; lk = '0; dst = '0; s1 = '0; s2 = '0; wd = '0;
      for (int i = 0; i < 16; i++) begin
         init_vals[i] = 16'($urandom);
         m_regs[i]    = init_vals[i];
      end
      model_reset();
      test_reset();
      test_write_read();
      test_round_robin();
      test_lock_sequence();
      test_lock_timeout();
      test_stalled_owner();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
